// File: rtl/cipher_block_fifo.sv
// rtl/cipher_block_fifo.sv - DEPTH-entry elastic buffer for ASCON cipher/tag words.
// Optional zero-latency empty fall-through enabled by macro CIPHER_FIFO_BYPASS_EN.
module cipher_block_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CW-1:0]    count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign ready_o = (r_count < FULL_CNT);

`ifdef CIPHER_FIFO_BYPASS_EN
    logic w_bypass;
    logic w_bypass_take;

    // An empty buffer forwards the producer word straight through; it is only
    // stored if the consumer is not taking it this cycle.
    assign w_bypass      = w_empty & valid_i & ~flush_i;
    assign w_bypass_take = w_bypass & ready_i;
    assign w_push        = valid_i & ready_o & ~w_bypass_take;
    assign w_pop         = ~w_empty & ready_i;
    assign valid_o       = ~w_empty | w_bypass;
    assign data_o        = w_bypass ? data_i : r_mem[r_rd_ptr];
`else
    assign w_push  = valid_i & ready_o;
    assign w_pop   = ~w_empty & ready_i;
    assign valid_o = ~w_empty;
    assign data_o  = r_mem[r_rd_ptr];
`endif

    assign count_o = r_count;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            // Memory is intentionally left intact; only the bookkeeping is cleared.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_block_fifo.sv
// tb/tb_cipher_block_fifo.sv - self-checking bench for cipher_block_fifo (DEPTH=4 and DEPTH=3).
module tb_cipher_block_fifo;

    logic        clock_i;
    logic        resetb_i;

    logic        a_flush, a_valid_i, a_ready_o, a_valid_o, a_ready_i;
    logic [63:0] a_data_i, a_data_o;
    logic [2:0]  a_count;

    logic        b_flush, b_valid_i, b_ready_o, b_valid_o, b_ready_i;
    logic [63:0] b_data_i, b_data_o;
    logic [1:0]  b_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] qa[$];
    logic [63:0] qb[$];

    cipher_block_fifo #(.WIDTH(64), .DEPTH(4)) u_dut_a (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .flush_i  (a_flush),
        .data_i   (a_data_i),
        .valid_i  (a_valid_i),
        .ready_o  (a_ready_o),
        .data_o   (a_data_o),
        .valid_o  (a_valid_o),
        .ready_i  (a_ready_i),
        .count_o  (a_count)
    );

    cipher_block_fifo #(.WIDTH(64), .DEPTH(3)) u_dut_b (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .flush_i  (b_flush),
        .data_i   (b_data_i),
        .valid_i  (b_valid_i),
        .ready_o  (b_ready_o),
        .data_o   (b_data_o),
        .valid_o  (b_valid_o),
        .ready_i  (b_ready_i),
        .count_o  (b_count)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // Reference: a bounded queue; flush empties it, a full queue refuses words,
    // an empty one emits nothing (except the fall-through in the bypass build).
    task automatic model_update(inout logic [63:0] q[$], input int depth,
                                input logic v, input logic [63:0] d,
                                input logic r, input logic f);
        bit can_push, can_pop;
        if (f) begin
            q.delete();
            return;
        end
`ifdef CIPHER_FIFO_BYPASS_EN
        if (q.size() == 0 && v && r) return;
`endif
        can_push = v && (q.size() < depth);
        can_pop  = r && (q.size() > 0);
        if (can_pop) void'(q.pop_front());
        if (can_push) q.push_back(d);
    endtask

    task automatic cyc_a(input logic v, input logic [63:0] d, input logic r, input logic f);
        a_valid_i = v; a_data_i = d; a_ready_i = r; a_flush = f;
        @(posedge clock_i);
        model_update(qa, 4, v, d, r, f);
        #1;
        a_valid_i = 1'b0; a_ready_i = 1'b0; a_flush = 1'b0;
        @(negedge clock_i);
    endtask

    task automatic cyc_b(input logic v, input logic [63:0] d, input logic r);
        b_valid_i = v; b_data_i = d; b_ready_i = r; b_flush = 1'b0;
        @(posedge clock_i);
        model_update(qb, 3, v, d, r, 1'b0);
        #1;
        b_valid_i = 1'b0; b_ready_i = 1'b0;
        @(negedge clock_i);
    endtask

    task automatic apply_reset();
        a_valid_i = 0; a_ready_i = 0; a_flush = 0; a_data_i = '0;
        b_valid_i = 0; b_ready_i = 0; b_flush = 0; b_data_i = '0;
        resetb_i = 1'b0;
        repeat (2) @(negedge clock_i);
        resetb_i = 1'b1;
        qa.delete();
        qb.delete();
        @(negedge clock_i);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({a_ready_o, a_valid_o, a_count} !== {1'b1, 1'b0, 3'd0} || a_data_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_a: ready=%b valid=%b count=%0d data=%h, want 1 0 0 0",
                     a_ready_o, a_valid_o, a_count, a_data_o);
        end
        checks++;
        if ({b_ready_o, b_valid_o, b_count} !== {1'b1, 1'b0, 2'd0} || b_data_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_b: ready=%b valid=%b count=%0d data=%h, want 1 0 0 0",
                     b_ready_o, b_valid_o, b_count, b_data_o);
        end
    endtask

    task automatic test_fill_drain();
        logic [63:0] unit;
        logic [63:0] exp;
        unit = 64'h1111_1111_1111_1111;
        for (int i = 1; i <= 4; i++) cyc_a(1'b1, unit * i, 1'b0, 1'b0);
        checks++;
        if (a_count !== 3'd4 || a_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: count=%0d ready=%b, want 4 0", a_count, a_ready_o);
        end
        cyc_a(1'b1, 64'h5555_5555_5555_5555, 1'b0, 1'b0);
        checks++;
        if (a_count !== 3'd4) begin
            errors++;
            $display("FAIL fill_fifth_rejected: count=%0d, want 4", a_count);
        end
        for (int i = 1; i <= 4; i++) begin
            exp = unit * i;
            checks++;
            if (a_valid_o !== 1'b1 || a_data_o !== exp) begin
                errors++;
                $display("FAIL drain_word%0d: valid=%b data=%h, want 1 %h", i, a_valid_o, a_data_o, exp);
            end
            cyc_a(1'b0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (a_valid_o !== 1'b0 || a_count !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b count=%0d, want 0 0", a_valid_o, a_count);
        end
    endtask

    task automatic test_stream();
        logic [63:0] exp_out[$];
        cyc_a(1'b1, 64'h100, 1'b0, 1'b0);
        cyc_a(1'b1, 64'h101, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) exp_out.push_back(64'h100 + i);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (a_count !== 3'd2 || a_valid_o !== 1'b1 || a_data_o !== exp_out[i]) begin
                errors++;
                $display("FAIL stream_%0d: count=%0d valid=%b data=%h, want 2 1 %h",
                         i, a_count, a_valid_o, a_data_o, exp_out[i]);
            end
            cyc_a(1'b1, 64'h102 + i, 1'b1, 1'b0);
        end
        for (int i = 10; i < 12; i++) begin
            checks++;
            if (a_data_o !== exp_out[i]) begin
                errors++;
                $display("FAIL stream_tail_%0d: data=%h, want %h", i, a_data_o, exp_out[i]);
            end
            cyc_a(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int popped = 0;
        int cycles = 0;
        logic v, r;
        while (popped < 7 && cycles < 200) begin
            checks++;
            if (b_count > 2'd3 || b_count !== 2'(qb.size()) ||
                (qb.size() > 0 && (b_valid_o !== 1'b1 || b_data_o !== qb[0]))) begin
                errors++;
                $display("FAIL wrap_c%0d: count=%0d valid=%b data=%h, want count %0d head %h",
                         cycles, b_count, b_valid_o, b_data_o, qb.size(),
                         (qb.size() > 0) ? qb[0] : 64'd0);
            end
            v = (pushed < 7) && ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) != 0);
            if (v && qb.size() < 3) pushed++;
            if (r && qb.size() > 0) popped++;
            cyc_b(v, 64'hB000 + pushed, r);
            cycles++;
        end
        checks++;
        if (popped != 7) begin
            errors++;
            $display("FAIL wrap_timeout: popped=%0d, want 7", popped);
        end
    endtask

    task automatic test_random();
        logic v, r, f;
        logic [63:0] d;
        for (int i = 0; i < 80; i++) begin
            checks++;
            if (a_count !== 3'(qa.size()) || a_valid_o !== (qa.size() != 0) ||
                a_ready_o !== (qa.size() < 4) ||
                (qa.size() > 0 && a_data_o !== qa[0])) begin
                errors++;
                $display("FAIL random_%0d: count=%0d valid=%b ready=%b data=%h, want count %0d head %h",
                         i, a_count, a_valid_o, a_ready_o, a_data_o, qa.size(),
                         (qa.size() > 0) ? qa[0] : 64'd0);
            end
            v = $urandom_range(0, 1);
            r = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 19) == 0);
            d = {$urandom, $urandom};
            cyc_a(v, d, r, f);
        end
        while (qa.size() > 0) cyc_a(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cyc_a(1'b1, 64'h300 + i, 1'b0, 1'b0);
        cyc_a(1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0, 1'b1);
        checks++;
        if (a_count !== 3'd0 || a_valid_o !== 1'b0 || a_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: count=%0d valid=%b ready=%b, want 0 0 1", a_count, a_valid_o, a_ready_o);
        end
        cyc_a(1'b1, 64'h77, 1'b0, 1'b0);
        checks++;
        if (a_valid_o !== 1'b1 || a_data_o !== 64'h77 || a_count !== 3'd1) begin
            errors++;
            $display("FAIL flush_next_word: valid=%b data=%h count=%0d, want 1 77 1", a_valid_o, a_data_o, a_count);
        end
        cyc_a(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cyc_a(1'b1, 64'h400 + i, 1'b0, 1'b0);
        #2;
        resetb_i = 1'b0;
        #1;
        checks++;
        if ({a_ready_o, a_valid_o, a_count} !== {1'b1, 1'b0, 3'd0} || a_data_o !== 64'd0) begin
            errors++;
            $display("FAIL async_reset: ready=%b valid=%b count=%0d data=%h, want 1 0 0 0",
                     a_ready_o, a_valid_o, a_count, a_data_o);
        end
        @(negedge clock_i);
        resetb_i = 1'b1;
        qa.delete();
        qb.delete();
        @(negedge clock_i);
    endtask

    task automatic test_bypass();
        a_valid_i = 1'b1; a_ready_i = 1'b1; a_flush = 1'b0;
        a_data_i = 64'hA5A5_A5A5_A5A5_A5A5;
        #1;
`ifdef CIPHER_FIFO_BYPASS_EN
        checks++;
        if (a_valid_o !== 1'b1 || a_data_o !== 64'hA5A5_A5A5_A5A5_A5A5 || a_count !== 3'd0) begin
            errors++;
            $display("FAIL bypass_same_cycle: valid=%b data=%h count=%0d, want 1 a5a5a5a5a5a5a5a5 0",
                     a_valid_o, a_data_o, a_count);
        end
`else
        checks++;
        if (a_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL nobypass_same_cycle: valid=%b, want 0", a_valid_o);
        end
`endif
        @(posedge clock_i);
        model_update(qa, 4, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 1'b0);
        #1;
        a_valid_i = 1'b0; a_ready_i = 1'b0;
        @(negedge clock_i);
`ifdef CIPHER_FIFO_BYPASS_EN
        checks++;
        if (a_count !== 3'd0 || a_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bypass_consumed: count=%0d valid=%b, want 0 0", a_count, a_valid_o);
        end
`else
        checks++;
        if (a_valid_o !== 1'b1 || a_data_o !== 64'hA5A5_A5A5_A5A5_A5A5 || a_count !== 3'd1) begin
            errors++;
            $display("FAIL nobypass_next_cycle: valid=%b data=%h count=%0d, want 1 a5a5a5a5a5a5a5a5 1",
                     a_valid_o, a_data_o, a_count);
        end
        cyc_a(1'b0, '0, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        resetb_i = 1'b0;
        @(negedge clock_i);
        test_reset();
        test_fill_drain();
        test_stream();
        test_wrap();
        test_random();
        test_flush();
        test_async_reset();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
